// File: rtl/xil_iobuf_ctrl_if.sv
// Bus bundle between a pad-bank controller and its user/IO-buffer side.
interface xil_iobuf_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  tx_valid;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_ready;
  logic                  rx_req;
  logic                  rx_valid;
  logic [DATA_WIDTH-1:0] rx_data;
  logic [DATA_WIDTH-1:0] dio_i;
  logic [DATA_WIDTH-1:0] dio_t;
  logic [DATA_WIDTH-1:0] dio_o;
  logic                  dir;
  logic                  turn;

  // User / pad side: issues requests and supplies the pad value.
  modport master (
    output tx_valid, tx_data, rx_req, dio_o,
    input  tx_ready, rx_valid, rx_data, dio_i, dio_t, dir, turn
  );

  // Controller side.
  modport slave (
    input  tx_valid, tx_data, rx_req, dio_o,
    output tx_ready, rx_valid, rx_data, dio_i, dio_t, dir, turn
  );
endinterface

// File: rtl/xil_iobuf_ctrl.sv
// Bidirectional pad-bank controller: arbitrates TX/RX bursts and inserts
// high-Z turnaround cycles on every direction change.
module xil_iobuf_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned TURN_CYC   = 2,
  parameter int unsigned MAX_BURST  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  xil_iobuf_ctrl_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
  localparam int unsigned TC_W  = 4;

  typedef enum logic [1:0] {
    S_IN   = 2'd0,
    S_OUT  = 2'd1,
    S_TURN = 2'd2
  } state_e;

  state_e                state_q, state_d;
  state_e                target_q, target_d;
  logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
  logic [TC_W-1:0]       turn_cnt_q, turn_cnt_d;
  logic [DATA_WIDTH-1:0] dio_i_q, dio_i_d;
  logic [DATA_WIDTH-1:0] dio_t_q, dio_t_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  dir_q, dir_d;
  logic                  turn_q, turn_d;

  logic own_req;
  logic other_req;
  logic at_max;
  logic go_turn;
  logic beat;

  // Requests seen from the currently owned direction; nothing is owned in turnaround.
  always_comb begin
    own_req   = 1'b0;
    other_req = 1'b0;
    case (state_q)
      S_IN: begin
        own_req   = bus.rx_req;
        other_req = bus.tx_valid;
      end
      S_OUT: begin
        own_req   = bus.tx_valid;
        other_req = bus.rx_req;
      end
      default: begin
        own_req   = 1'b0;
        other_req = 1'b0;
      end
    endcase
  end

  // Burst limit only yields the bus when the opposite side is actually waiting.
  always_comb begin
    at_max  = (beat_cnt_q == CNT_W'(MAX_BURST));
    go_turn = other_req && (!own_req || at_max);
    beat    = own_req && !(at_max && other_req);
  end

  // Accept is independent of tx_valid so the user may wait on it.
  assign bus.tx_ready = (state_q == S_OUT) && !(at_max && bus.rx_req);

  // Next-state and registered-output computation.
  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    beat_cnt_d = beat_cnt_q;
    turn_cnt_d = turn_cnt_q;
    dio_i_d    = dio_i_q;
    dio_t_d    = dio_t_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    dir_d      = dir_q;
    turn_d     = turn_q;

    case (state_q)
      S_TURN: begin
        if (turn_cnt_q == TC_W'(0)) begin
          state_d    = target_q;
          beat_cnt_d = CNT_W'(0);
          turn_d     = 1'b0;
          dir_d      = (target_q == S_OUT);
        end else begin
          turn_cnt_d = turn_cnt_q - TC_W'(1);
        end
      end
      S_IN, S_OUT: begin
        if (go_turn) begin
          state_d    = S_TURN;
          target_d   = (state_q == S_IN) ? S_OUT : S_IN;
          turn_cnt_d = TC_W'(TURN_CYC - 1);
          dio_t_d    = '1;
          turn_d     = 1'b1;
          dir_d      = (state_q == S_IN);
        end else if (beat) begin
          beat_cnt_d = at_max ? CNT_W'(1) : (beat_cnt_q + CNT_W'(1));
          if (state_q == S_IN) begin
            rx_data_d  = bus.dio_o;
            rx_valid_d = 1'b1;
          end else begin
            dio_i_d = bus.tx_data;
            dio_t_d = '0;
          end
        end
      end
      default: begin
        state_d    = S_IN;
        dio_t_d    = '1;
        dir_d      = 1'b0;
        turn_d     = 1'b0;
      end
    endcase
  end

  // State and output registers; reset releases the pads immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IN;
      target_q   <= S_IN;
      beat_cnt_q <= '0;
      turn_cnt_q <= '0;
      dio_i_q    <= '0;
      dio_t_q    <= '1;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      dir_q      <= 1'b0;
      turn_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      beat_cnt_q <= beat_cnt_d;
      turn_cnt_q <= turn_cnt_d;
      dio_i_q    <= dio_i_d;
      dio_t_q    <= dio_t_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      dir_q      <= dir_d;
      turn_q     <= turn_d;
    end
  end

  assign bus.dio_i    = dio_i_q;
  assign bus.dio_t    = dio_t_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.dir      = dir_q;
  assign bus.turn     = turn_q;

endmodule

// File: tb/tb_xil_iobuf_ctrl.sv
// Scoreboard bench for xil_iobuf_ctrl with a behavioural pad-bus model.
module tb_xil_iobuf_ctrl;

  localparam int unsigned DW   = 8;
  localparam int          TURN = 2;
  localparam int          MAXB = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  xil_iobuf_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  xil_iobuf_ctrl #(
    .DATA_WIDTH(DW),
    .TURN_CYC  (TURN),
    .MAX_BURST (MAXB)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic       tx_ready;
    logic       turn;
    logic       dir;
    logic       rx_valid;
    logic [7:0] dio_t;
    logic [7:0] dio_i;
  } exp_t;

  exp_t       cyc_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];

  // Reference model: who owns the bus, how long the current run is, what the pads show.
  int         m_mode;   // 0 inbound, 1 outbound, 2 turning
  int         m_tgt;
  int         m_left;
  int         m_run;
  bit         m_drive;
  logic [7:0] m_pad;
  bit         m_rxv;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode  = 0;
    m_tgt   = 0;
    m_left  = 0;
    m_run   = 0;
    m_drive = 0;
    m_pad   = 8'h00;
    m_rxv   = 0;
  endtask

  // One cycle of the model: record what this cycle must show, then advance.
  task automatic step(input bit tv, input logic [7:0] td, input bit rr, input logic [7:0] din);
    exp_t e;
    bit   own, other, yield, beat;
    e.turn     = (m_mode == 2);
    e.dir      = (m_mode == 1) || (m_mode == 2 && m_tgt == 1);
    e.dio_t    = m_drive ? 8'h00 : 8'hFF;
    e.dio_i    = m_pad;
    e.rx_valid = m_rxv;
    e.tx_ready = (m_mode == 1) && !(m_run == MAXB && rr);
    cyc_q.push_back(e);

    own   = (m_mode == 0) ? rr : tv;
    other = (m_mode == 0) ? tv : rr;
    yield = (m_mode != 2) && other && (!own || m_run == MAXB);
    beat  = (m_mode != 2) && own && !yield;
    m_rxv = 0;
    if (m_mode == 2) begin
      m_left--;
      if (m_left == 0) begin
        m_mode = m_tgt;
        m_run  = 0;
      end
    end else if (yield) begin
      m_tgt   = 1 - m_mode;
      m_mode  = 2;
      m_left  = TURN;
      m_drive = 0;
    end else if (beat) begin
      m_run = (m_run == MAXB) ? 1 : m_run + 1;
      if (m_mode == 0) begin
        m_rxv = 1;
        rx_q.push_back(din);
      end else begin
        m_pad   = td;
        m_drive = 1;
        tx_q.push_back(td);
      end
    end
  endtask

  task automatic cyc(input bit tv, input logic [7:0] td, input bit rr, input logic [7:0] din);
    @(posedge clk);
    #1;
    bus.tx_valid = tv;
    bus.tx_data  = td;
    bus.rx_req   = rr;
    bus.dio_o    = din;
    step(tv, td, rr, din);
  endtask

  // Monitor: compares whatever the DUT presents against queued expectations.
  exp_t       mon_e;
  bit         tx_pend       = 0;
  logic [7:0] last_acc      = 8'h00;
  bit         prev_released = 1;

  always @(negedge clk) begin
    if (!rst_n) begin
      cyc_q.delete();
      tx_q.delete();
      rx_q.delete();
      tx_pend       = 0;
      last_acc      = 8'h00;
      prev_released = 1;
    end else begin
      if (tx_pend) begin
        tx_pend = 0;
        chk("tx_beat_expected", 32'(tx_q.size() != 0), 32'd1);
        if (tx_q.size() != 0) begin
          last_acc = tx_q.pop_front();
          chk("tx_pad_data", 32'(bus.dio_i), 32'(last_acc));
        end
      end
      if (bus.rx_valid) begin
        chk("rx_beat_expected", 32'(rx_q.size() != 0), 32'd1);
        if (rx_q.size() != 0) chk("rx_data", 32'(bus.rx_data), 32'(rx_q.pop_front()));
        chk("rx_after_released", 32'(prev_released), 32'd1);
      end
      if (bus.dio_t == 8'h00) chk("driven_is_last_acc", 32'(bus.dio_i), 32'(last_acc));
      if (cyc_q.size() != 0) begin
        mon_e = cyc_q.pop_front();
        chk("tx_ready", 32'(bus.tx_ready), 32'(mon_e.tx_ready));
        chk("turn", 32'(bus.turn), 32'(mon_e.turn));
        chk("dir", 32'(bus.dir), 32'(mon_e.dir));
        chk("rx_valid", 32'(bus.rx_valid), 32'(mon_e.rx_valid));
        chk("dio_t", 32'(bus.dio_t), 32'(mon_e.dio_t));
        chk("dio_i", 32'(bus.dio_i), 32'(mon_e.dio_i));
      end
      if (bus.tx_valid && bus.tx_ready) tx_pend = 1;
      prev_released = (bus.dio_t == 8'hFF);
    end
  end

  task automatic check_reset_values(input string tag);
    chk({tag, "_dio_t"}, 32'(bus.dio_t), 32'h0000_00FF);
    chk({tag, "_dio_i"}, 32'(bus.dio_i), 32'd0);
    chk({tag, "_rx_valid"}, 32'(bus.rx_valid), 32'd0);
    chk({tag, "_rx_data"}, 32'(bus.rx_data), 32'd0);
    chk({tag, "_dir"}, 32'(bus.dir), 32'd0);
    chk({tag, "_turn"}, 32'(bus.turn), 32'd0);
    chk({tag, "_tx_ready"}, 32'(bus.tx_ready), 32'd0);
  endtask

  initial begin
    int p;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    bus.rx_req   = 1'b0;
    bus.dio_o    = 8'h00;
    model_reset();

    // Reset takes effect with no clock edge.
    #1 rst_n = 1'b0;
    #1;
    check_reset_values("por");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    model_reset();

    // Three consecutive samples.
    cyc(0, 8'h00, 1, 8'h11);
    cyc(0, 8'h00, 1, 8'h22);
    cyc(0, 8'h00, 1, 8'h33);
    cyc(0, 8'h00, 0, 8'h00);
    cyc(0, 8'h00, 0, 8'h00);

    // Turn to outbound, two beats, bus parks driven.
    repeat (4) cyc(1, 8'hA5, 0, 8'h00);
    cyc(1, 8'h5A, 0, 8'h00);
    repeat (3) cyc(0, 8'h00, 0, 8'h00);

    // Both sides requesting: alternating bursts with turnarounds.
    for (int i = 0; i < 30; i++) cyc(1, 8'($urandom), 1, 8'($urandom));

    // Outbound only: no burst limit applies.
    for (int i = 0; i < 14; i++) cyc(1, 8'($urandom), 0, 8'($urandom));

    // Random traffic with shifting bias.
    for (int i = 0; i < 400; i++) begin
      p = (i < 130) ? 75 : (i < 260) ? 25 : 50;
      cyc(bit'($urandom_range(0, 99) < p), 8'($urandom),
          bit'($urandom_range(0, 99) < (100 - p)), 8'($urandom));
    end

    // Reach an outbound burst, then reset in the middle of it.
    for (int i = 0; i < 12 && !(m_mode == 1 && m_run >= 1); i++)
      cyc(1, 8'($urandom), 0, 8'h00);
    cyc(1, 8'h77, 0, 8'h00);
    @(posedge clk);
    #1;
    bus.tx_data = 8'h99;
    chk("pre_rst_tx_ready", 32'(bus.tx_ready), 32'd1);
    chk("pre_rst_dio_t", 32'(bus.dio_t), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check_reset_values("mid_rst");
    bus.tx_valid = 1'b0;
    bus.rx_req   = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    model_reset();

    // Inbound immediately after reset: no turnaround needed.
    cyc(0, 8'h00, 1, 8'h3C);
    cyc(1, 8'h42, 0, 8'h00);
    for (int i = 0; i < 60; i++)
      cyc(bit'($urandom_range(0, 1)), 8'($urandom), bit'($urandom_range(0, 1)), 8'($urandom));

    repeat (6) cyc(0, 8'h00, 0, 8'h00);
    @(negedge clk);
    #1;
    chk("tx_q_drained", 32'(tx_q.size()), 32'd0);
    chk("rx_q_drained", 32'(rx_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xil_iobuf_ctrl.md
XIL_IOBUF_CTRL -- requirements
Module: xil_iobuf_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8, pad bank width in bits.
REQ-002 Parameter TURN_CYC, default 2, high-Z turnaround cycles on every direction change; legal range 1..15.
REQ-003 Parameter MAX_BURST, default 16, maximum consecutive beats in one direction while the opposite side requests; legal range 1..255.
REQ-004 Port clk  input  1  single clock, all state on rising edge.
REQ-005 Port rst_n  input  1  asynchronous, active-low reset.
REQ-006 Port tx_valid  input  1  transmit beat available.
REQ-007 Port tx_data  input  DATA_WIDTH  transmit beat.
REQ-008 Port tx_ready  output  1  transmit beat accepted this cycle when tx_valid=1.
REQ-009 Port rx_req  input  1  request to sample pads this cycle.
REQ-010 Port rx_valid  output  1  rx_data valid, one-cycle pulse per sample.
REQ-011 Port rx_data  output  DATA_WIDTH  sampled pad value.
REQ-012 Port dio_i  output  DATA_WIDTH  to IO buffer, value driven onto pads.
REQ-013 Port dio_t  output  DATA_WIDTH  to IO buffer, per-bit tristate, 1 = high-Z (input), 0 = drive.
REQ-014 Port dio_o  input  DATA_WIDTH  from IO buffer, pad value.
REQ-015 Port dir  output  1  0 = bus inbound/released, 1 = outbound; reflects current or target direction.
REQ-016 Port turn  output  1  1 while in turnaround.

Function
REQ-017 State machine SHALL have states S_IN, S_OUT, S_TURN; beat counter beat_cnt (0..MAX_BURST) and turnaround counter.
REQ-018 own_req = rx_req in S_IN, tx_valid in S_OUT; other_req = the opposite signal.
REQ-019 Beat SHALL occur in S_IN/S_OUT cycle iff own_req=1 and not (beat_cnt==MAX_BURST and other_req=1).
REQ-020 tx_ready SHALL be combinational: 1 iff state S_OUT and beat condition excluding tx_valid holds; 0 in S_IN and S_TURN.
REQ-021 On TX beat: dio_i <= tx_data, dio_t <= all 0 at same edge; data appears on pads the following cycle.
REQ-022 In S_OUT without beat, dio_i and dio_t SHALL hold (bus parks driven with last value).
REQ-023 On RX beat: rx_data <= dio_o and rx_valid <= 1 at that edge; rx_valid SHALL be 0 in every other cycle.
REQ-024 beat_cnt SHALL increment on beat; beat when beat_cnt==MAX_BURST (other_req=0) SHALL set beat_cnt to 1; cleared to 0 on entry to S_IN/S_OUT.
REQ-025 S_IN/S_OUT SHALL go to S_TURN when other_req=1 and (own_req=0 or beat_cnt==MAX_BURST); no beat in that cycle.
REQ-026 On entry to S_TURN, dio_t <= all 1 at that edge; dio_t SHALL remain all 1 throughout S_TURN; dio_i holds.
REQ-027 S_TURN SHALL last exactly TURN_CYC cycles, then enter the target state; dir shows target state from S_TURN entry.
REQ-028 Requests during S_TURN SHALL be ignored (no beats, tx_ready=0); new target is not re-evaluated.
REQ-029 No request on either side: state, beat_cnt and pad outputs SHALL hold.
REQ-030 Same-direction back-to-back beats SHALL have zero gap; every direction change SHALL insert exactly TURN_CYC high-Z cycles.

Reset
REQ-031 While rst_n=0 (immediately, no clock needed): state S_IN, dio_t all 1, dio_i 0, rx_data 0, rx_valid 0, beat_cnt 0, turnaround counter 0, dir 0, turn 0, tx_ready 0.
REQ-032 Reset mid-S_OUT or mid-S_TURN SHALL release pads asynchronously; any in-flight beat is discarded.

Verification (TURN_CYC=2, MAX_BURST=4, DATA_WIDTH=8)
REQ-033 Reset, rx_req=1 3 cycles, dio_o=0x11,0x22,0x33 -> rx_valid 3 consecutive cycles 1 cycle later, rx_data 0x11,0x22,0x33, dio_t=0xFF throughout.
REQ-034 From S_IN, tx_valid=1 with 0xA5,0x5A -> 2 cycles turn=1/dio_t=0xFF, then tx_ready=1, dio_i=0xA5 then 0x5A with dio_t=0x00; bus stays driven 0x5A after tx_valid drops.
REQ-035 tx_valid and rx_req held 1 from S_OUT -> exactly 4 TX beats, 2-cycle turn, 4 RX beats, 2-cycle turn, repeating; never a beat during turn.
REQ-036 tx_valid held, rx_req=0 -> continuous tx_ready beyond 4 beats, no turnaround inserted.
REQ-037 rst_n asserted mid-TX burst -> dio_t=0xFF before next clock edge, tx_ready=0, state S_IN after release.
REQ-038 Bench checker: every cycle dio_t=0x00 implies dio_i equals last accepted tx_data; no cycle with rx_valid=1 follows a cycle with dio_t≠0xFF.
